// File: rtl/sram_1kbyte_1rw1r_32x256_if.sv
// Purpose: bus bundle for the 1rw1r SRAM macro (port 0 read/write, port 1 read-only).
// Signals:
//   csb0   - port-0 chip select, active low
//   web0   - port-0 write enable, active low (1 = read)
//   wmask0 - port-0 byte-write mask, bit i enables din0 byte i
//   addr0  - port-0 word address
//   din0   - port-0 write data
//   dout0  - port-0 registered read data
//   csb1   - port-1 chip select, active low
//   addr1  - port-1 word address
//   dout1  - port-1 registered read data
// Modports: master drives the controls, slave is the macro.
interface sram_1kbyte_1rw1r_32x256_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
);
    localparam int unsigned NUM_WMASKS = DATA_WIDTH / 8;

    logic                  csb0;
    logic                  web0;
    logic [NUM_WMASKS-1:0] wmask0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic [DATA_WIDTH-1:0] dout0;
    logic                  csb1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] dout1;

    modport master (
        output csb0, web0, wmask0, addr0, din0, csb1, addr1,
        input  dout0, dout1
    );

    modport slave (
        input  csb0, web0, wmask0, addr0, din0, csb1, addr1,
        output dout0, dout1
    );
endinterface

// File: rtl/sram_1kbyte_1rw1r_32x256.sv
// Purpose: behavioural 256 x 32 SRAM macro with one read/write port (byte-masked
// writes) and one read-only port, both with one-cycle registered read data.
// Ports:
//   clk0  - single clock, all accesses sample on its rising edge
//   rst_n - asynchronous active-low reset; clears dout0/dout1, not the array
//   bus   - slave side of sram_1kbyte_1rw1r_32x256_if (port 0 and port 1 signals)
module sram_1kbyte_1rw1r_32x256 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int unsigned NUM_WMASKS = DATA_WIDTH / 8
) (
    input  logic                         clk0,
    input  logic                         rst_n,
    sram_1kbyte_1rw1r_32x256_if.slave    bus
);
    localparam int unsigned BYTE_WIDTH = 8;

    // Storage is deliberately left without reset: contents survive rst_n.
    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic wr_en0_c;
    logic rd_en0_c;
    logic rd_en1_c;

    // Access decode for both ports.
    always_comb begin
        wr_en0_c = 1'b0;
        rd_en0_c = 1'b0;
        rd_en1_c = 1'b0;
        if (!bus.csb0) begin
            wr_en0_c = !bus.web0;
            rd_en0_c = bus.web0;
        end
        rd_en1_c = !bus.csb1;
    end

    // Byte-masked array write; rst_n gates it so nothing is written while in reset.
    always_ff @(posedge clk0) begin
        if (rst_n && wr_en0_c) begin
            for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
                if (bus.wmask0[i]) begin
                    mem[bus.addr0][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.din0[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Port-0 read register; holds on writes and deselected cycles.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            bus.dout0 <= '0;
        end else if (rd_en0_c) begin
            bus.dout0 <= mem[bus.addr0];
        end
    end

    // Port-1 read register; a same-edge port-0 write is not visible (old data).
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            bus.dout1 <= '0;
        end else if (rd_en1_c) begin
            bus.dout1 <= mem[bus.addr1];
        end
    end
endmodule

// File: tb/tb_sram_1kbyte_1rw1r_32x256.sv
// Purpose: directed self-checking bench for sram_1kbyte_1rw1r_32x256.
module tb_sram_1kbyte_1rw1r_32x256;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    sram_1kbyte_1rw1r_32x256_if bus ();

    sram_1kbyte_1rw1r_32x256 dut (
        .clk0  (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.csb0   = 1'b1;
        bus.web0   = 1'b1;
        bus.wmask0 = 4'h0;
        bus.addr0  = 8'h00;
        bus.din0   = 32'h0;
        bus.csb1   = 1'b1;
        bus.addr1  = 8'h00;
    endtask

    task automatic wr0(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
        bus.csb0   = 1'b0;
        bus.web0   = 1'b0;
        bus.addr0  = a;
        bus.din0   = d;
        bus.wmask0 = m;
    endtask

    task automatic rd0(input logic [7:0] a);
        bus.csb0   = 1'b0;
        bus.web0   = 1'b1;
        bus.addr0  = a;
        bus.din0   = 32'h0BAD_0BAD;
        bus.wmask0 = 4'hF;
    endtask

    task automatic rd1(input logic [7:0] a);
        bus.csb1  = 1'b0;
        bus.addr1 = a;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        idle();
        cyc();
        cyc();
        check_eq("reset_dout0", bus.dout0, 32'h0);
        check_eq("reset_dout1", bus.dout1, 32'h0);
        rst_n = 1'b1;

        // Basic write/read
        wr0(8'h10, 32'hDEADBEEF, 4'hF);
        cyc();
        check_eq("write_hold_dout0", bus.dout0, 32'h0);
        rd0(8'h10);
        cyc();
        check_eq("basic_read", bus.dout0, 32'hDEADBEEF);

        // Byte masking
        wr0(8'h10, 32'h11223344, 4'b0101);
        cyc();
        check_eq("mask_write_hold", bus.dout0, 32'hDEADBEEF);
        rd0(8'h10);
        cyc();
        check_eq("mask_read", bus.dout0, 32'hDE22BE44);
        wr0(8'h10, 32'h00000000, 4'b0000);
        cyc();
        rd0(8'h10);
        cyc();
        check_eq("mask_zero_read", bus.dout0, 32'hDE22BE44);

        // Deselected write attempt must not touch the array
        wr0(8'h10, 32'hFFFFFFFF, 4'hF);
        bus.csb0 = 1'b1;
        cyc();
        check_eq("desel_hold", bus.dout0, 32'hDE22BE44);
        idle();
        cyc();
        check_eq("idle_hold", bus.dout0, 32'hDE22BE44);
        rd0(8'h10);
        cyc();
        check_eq("desel_read", bus.dout0, 32'hDE22BE44);
        check_eq("port1_parked", bus.dout1, 32'h0);

        // Collision: port 1 sees old word
        wr0(8'h10, 32'hCAFEF00D, 4'hF);
        rd1(8'h10);
        cyc();
        check_eq("collision_dout1", bus.dout1, 32'hDE22BE44);
        rd0(8'h10);
        rd1(8'h10);
        cyc();
        check_eq("after_coll_dout1", bus.dout1, 32'hCAFEF00D);
        check_eq("after_coll_dout0", bus.dout0, 32'hCAFEF00D);

        // Boundary addresses
        idle();
        wr0(8'h00, 32'hA5A5A5A5, 4'hF);
        cyc();
        wr0(8'hFF, 32'h5A5A5A5A, 4'hF);
        cyc();
        rd0(8'h00);
        rd1(8'hFF);
        cyc();
        check_eq("bound_p0_00", bus.dout0, 32'hA5A5A5A5);
        check_eq("bound_p1_ff", bus.dout1, 32'h5A5A5A5A);
        rd0(8'hFF);
        rd1(8'h00);
        cyc();
        check_eq("bound_p0_ff", bus.dout0, 32'h5A5A5A5A);
        check_eq("bound_p1_00", bus.dout1, 32'hA5A5A5A5);
        idle();
        cyc();
        check_eq("p1_desel_hold", bus.dout1, 32'hA5A5A5A5);

        // Reset mid-operation: asynchronous clear, write during reset dropped
        rd0(8'h10);
        rd1(8'h10);
        cyc();
        check_eq("pre_reset_dout0", bus.dout0, 32'hCAFEF00D);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_dout0", bus.dout0, 32'h0);
        check_eq("async_rst_dout1", bus.dout1, 32'h0);
        idle();
        wr0(8'h10, 32'hFFFFFFFF, 4'hF);
        cyc();
        check_eq("in_rst_dout0", bus.dout0, 32'h0);
        rd0(8'h10);
        rd1(8'h10);
        rst_n = 1'b1;
        cyc();
        check_eq("post_rst_dout0", bus.dout0, 32'hCAFEF00D);
        check_eq("post_rst_dout1", bus.dout1, 32'hCAFEF00D);

        idle();
        cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
